// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter sharing the register file write port between ALU (req0) and load (req1) results.
// Optional read-side forwarding of the pending write is enabled with `define WB_FWD_EN.
module reg_wb_arbiter #(
   parameter int N            = 5,
   parameter int M            = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0_valid,
   input  logic [N-1:0] req0_addr,
   input  logic [M-1:0] req0_data,
   output logic         req0_ready,
   input  logic         req1_valid,
   input  logic [N-1:0] req1_addr,
   input  logic [M-1:0] req1_data,
   output logic         req1_ready,
   input  logic         stall,
   output logic         wb_we,
   output logic [N-1:0] wb_addr,
   output logic [M-1:0] wb_data,
   output logic [1:0]   state
`ifdef WB_FWD_EN
   ,
   input  logic [N-1:0] rd_addr1,
   input  logic [N-1:0] rd_addr2,
   output logic         fwd1_hit,
   output logic         fwd2_hit,
   output logic [M-1:0] fwd_data
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      STALL = 2'd2
   } state_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t     cur_state, nxt_state;
   logic [3:0] starve_cnt;
   logic       starved;
   logic       grant0, grant1;

   // Loads win by default; the ALU wins once it has been denied LIMIT cycles in a row.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      grant0  = 1'b0;
      grant1  = 1'b0;
      starved = (starve_cnt == LIMIT);
      if (rst_n && !stall) begin
         if (req0_valid && (!req1_valid || starved))
            grant0 = 1'b1;
         else if (req1_valid)
            grant1 = 1'b1;
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   always_comb begin
      nxt_state = IDLE;
      if (stall)
         nxt_state = STALL;
      else if (grant0 || grant1)
         nxt_state = WRITE;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_state  <= IDLE;
         starve_cnt <= '0;
         wb_we      <= 1'b0;
         wb_addr    <= '0;
         wb_data    <= '0;
      end else begin
         cur_state <= nxt_state;
         if (!stall) begin
            // Writes to register 0 are consumed but never reach the register file.
            if (grant0) begin
               wb_addr <= req0_addr;
               wb_data <= req0_data;
               wb_we   <= (req0_addr != '0);
            end else if (grant1) begin
               wb_addr <= req1_addr;
               wb_data <= req1_data;
               wb_we   <= (req1_addr != '0);
            end else begin
               wb_we   <= 1'b0;
            end

            if (!req0_valid || grant0)
               starve_cnt <= '0;
            else if (starve_cnt != LIMIT)
               starve_cnt <= starve_cnt + 4'd1;
         end
      end
   end

   assign state = cur_state;

`ifdef WB_FWD_EN
   // The registered write is not yet in the register file, so readers of that address take it from here.
   assign fwd1_hit = wb_we && (wb_addr == rd_addr1) && (rd_addr1 != '0);
   assign fwd2_hit = wb_we && (wb_addr == rd_addr2) && (rd_addr2 != '0);
   assign fwd_data = wb_data;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the grant, output register and starvation rules.
module tb_reg_wb_arbiter;
   localparam int N     = 5;
   localparam int M     = 32;
   localparam int LIMIT = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req0_valid, req1_valid, stall;
   logic [N-1:0] req0_addr, req1_addr;
   logic [M-1:0] req0_data, req1_data;
   logic         req0_ready, req1_ready;
   logic         wb_we;
   logic [N-1:0] wb_addr;
   logic [M-1:0] wb_data;
   logic [1:0]   state;
`ifdef WB_FWD_EN
   logic [N-1:0] rd_addr1, rd_addr2;
   logic         fwd1_hit, fwd2_hit;
   logic [M-1:0] fwd_data;
`endif

   int errors = 0;
   int checks = 0;

   // Reference model: what the write port should show after each edge.
   logic         m_we;
   logic [N-1:0] m_addr;
   logic [M-1:0] m_data;
   logic [1:0]   m_state;
   int           m_cnt;
   logic         e_r0, e_r1;

   logic [M+N+2:0] dut_out;
   assign dut_out = {wb_we, wb_addr, wb_data, state};

   reg_wb_arbiter #(.N(N), .M(M), .STARVE_LIMIT(LIMIT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_addr  (req0_addr),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_addr  (req1_addr),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .stall      (stall),
      .wb_we      (wb_we),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .state      (state)
`ifdef WB_FWD_EN
      ,
      .rd_addr1   (rd_addr1),
      .rd_addr2   (rd_addr2),
      .fwd1_hit   (fwd1_hit),
      .fwd2_hit   (fwd2_hit),
      .fwd_data   (fwd_data)
`endif
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_we = 1'b0; m_addr = '0; m_data = '0; m_state = 2'd0; m_cnt = 0;
      e_r0 = 1'b0; e_r1 = 1'b0;
   endtask

   // Drive one cycle of inputs away from the edge and predict the grant from the priority rules.
   task automatic apply(input logic v0, input logic [N-1:0] a0, input logic [M-1:0] d0,
                        input logic v1, input logic [N-1:0] a1, input logic [M-1:0] d1,
                        input logic st);
      @(negedge clk);
      req0_valid = v0; req0_addr = a0; req0_data = d0;
      req1_valid = v1; req1_addr = a1; req1_data = d1;
      stall = st;
      #1;
      e_r0 = 1'b0; e_r1 = 1'b0;
      if (!st) begin
         if (v0 && v1) begin
            if (m_cnt == LIMIT) e_r0 = 1'b1;
            else                e_r1 = 1'b1;
         end else if (v0) e_r0 = 1'b1;
         else if (v1)     e_r1 = 1'b1;
      end
   endtask

   // Advance one edge and update the model's view of the write port and starvation count.
   task automatic tick();
      @(posedge clk);
      if (stall) begin
         m_state = 2'd2;
      end else begin
         if (e_r0) begin
            m_addr = req0_addr; m_data = req0_data; m_we = (req0_addr != 0);
         end else if (e_r1) begin
            m_addr = req1_addr; m_data = req1_data; m_we = (req1_addr != 0);
         end else begin
            m_we = 1'b0;
         end
         m_state = (e_r0 || e_r1) ? 2'd1 : 2'd0;
         if (req0_valid && !e_r0) m_cnt = (m_cnt + 1 > LIMIT) ? LIMIT : m_cnt + 1;
         else                     m_cnt = 0;
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h1;
      req1_valid = 1'b1; req1_addr = 5'd10; req1_data = 32'h2;
      stall = 1'b0;
      model_reset();
      #3;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
         errors++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready});
      end
      checks++;
      if (dut_out !== '0) begin
         errors++; $display("FAIL reset_out: got %h want 0", dut_out);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk); rst_n = 1'b1;

      // Asynchronous reset arriving while a write is on the port.
      apply(1'b1, 5'd12, 32'hCAFE_0001, 1'b0, '0, '0, 1'b0);
      tick();
      checks++;
      if (dut_out !== {1'b1, 5'd12, 32'hCAFE_0001, 2'd1}) begin
         errors++; $display("FAIL reset_prewrite: got %h want %h", dut_out, {1'b1, 5'd12, 32'hCAFE_0001, 2'd1});
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (dut_out !== '0) begin
         errors++; $display("FAIL reset_async: got %h want 0", dut_out);
      end
      model_reset();
      req0_valid = 1'b0;
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_single();
      apply(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, '0, 1'b0);
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         errors++; $display("FAIL single_ready: got %b want 10", {req0_ready, req1_ready});
      end
      tick();
      checks++;
      if (dut_out !== {1'b1, 5'd5, 32'hDEAD_BEEF, 2'd1}) begin
         errors++; $display("FAIL single_write: got %h want %h", dut_out, {1'b1, 5'd5, 32'hDEAD_BEEF, 2'd1});
      end
      apply(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
      tick();
      checks++;
      if (dut_out !== {1'b0, 5'd5, 32'hDEAD_BEEF, 2'd0}) begin
         errors++; $display("FAIL single_idle: got %h want %h", dut_out, {1'b0, 5'd5, 32'hDEAD_BEEF, 2'd0});
      end
   endtask

   // Both valid every cycle: four load grants, then the starved ALU, then loads again.
   task automatic test_contention();
      logic [1:0] want;
      for (int i = 0; i < 6; i++) begin
         apply(1'b1, 5'd3, 32'h1111_0000, 1'b1, 5'(i + 8), 32'h2222_0000 + i, 1'b0);
         want = (i == 4) ? 2'b10 : 2'b01;
         checks++;
         if ({req0_ready, req1_ready} !== want) begin
            errors++; $display("FAIL contention_grant%0d: got %b want %b", i, {req0_ready, req1_ready}, want);
         end
         tick();
         checks++;
         if (dut_out !== {m_we, m_addr, m_data, m_state}) begin
            errors++; $display("FAIL contention_out%0d: got %h want %h", i, dut_out, {m_we, m_addr, m_data, m_state});
         end
      end
      apply(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
      tick();
   endtask

   task automatic test_x0();
      apply(1'b0, '0, '0, 1'b1, 5'd0, 32'h0000_1234, 1'b0);
      checks++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
         errors++; $display("FAIL x0_ready: got %b want 01", {req0_ready, req1_ready});
      end
      tick();
      checks++;
      if ({wb_we, wb_addr, wb_data} !== {1'b0, 5'd0, 32'h0000_1234}) begin
         errors++; $display("FAIL x0_we: got %h want %h", {wb_we, wb_addr, wb_data}, {1'b0, 5'd0, 32'h0000_1234});
      end
   endtask

   // Stall in the middle of a starvation run: the count must survive the stall.
   task automatic test_stall();
      logic [M+N+2:0] held;
      logic [1:0]     want;
      apply(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
      tick();
      for (int i = 0; i < 2; i++) begin
         apply(1'b1, 5'd4, 32'h4444_4444, 1'b1, 5'(i + 20), 32'h5555_0000 + i, 1'b0);
         tick();
      end
      held = {wb_we, wb_addr, wb_data, 2'd2};
      for (int i = 0; i < 3; i++) begin
         apply(1'b1, 5'd4, 32'h4444_4444, 1'b1, 5'd22, 32'h5555_0002, 1'b1);
         checks++;
         if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++; $display("FAIL stall_ready%0d: got %b want 00", i, {req0_ready, req1_ready});
         end
         tick();
         checks++;
         if (dut_out !== held) begin
            errors++; $display("FAIL stall_hold%0d: got %h want %h", i, dut_out, held);
         end
      end
      for (int i = 0; i < 3; i++) begin
         apply(1'b1, 5'd4, 32'h4444_4444, 1'b1, 5'(i + 22), 32'h5555_0002 + i, 1'b0);
         want = (i == 2) ? 2'b10 : 2'b01;
         checks++;
         if ({req0_ready, req1_ready} !== want) begin
            errors++; $display("FAIL stall_resume%0d: got %b want %b", i, {req0_ready, req1_ready}, want);
         end
         tick();
      end
      apply(1'b1, 5'd6, 32'h6666_6666, 1'b0, '0, '0, 1'b0);
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         errors++; $display("FAIL stall_req0: got %b want 10", {req0_ready, req1_ready});
      end
      tick();
   endtask

   // Requesters hold each request until accepted; stalls and x0 targets are mixed in.
   task automatic test_random();
      logic         p0v, p1v;
      logic [N-1:0] p0a, p1a;
      logic [M-1:0] p0d, p1d;
      p0v = 1'b0; p1v = 1'b0; p0a = '0; p1a = '0; p0d = '0; p1d = '0;
      for (int i = 0; i < 400; i++) begin
         if (!p0v && ($urandom_range(0, 2) != 0)) begin
            p0v = 1'b1; p0a = 5'($urandom_range(0, 31)); p0d = $urandom;
         end
         if (!p1v && ($urandom_range(0, 2) != 0)) begin
            p1v = 1'b1; p1a = 5'($urandom_range(0, 31)); p1d = $urandom;
         end
         apply(p0v, p0a, p0d, p1v, p1a, p1d, ($urandom_range(0, 3) == 0));
         checks++;
         if ({req0_ready, req1_ready} !== {e_r0, e_r1}) begin
            errors++; $display("FAIL rand_ready%0d: got %b want %b", i, {req0_ready, req1_ready}, {e_r0, e_r1});
         end
         tick();
         checks++;
         if (dut_out !== {m_we, m_addr, m_data, m_state}) begin
            errors++; $display("FAIL rand_out%0d: got %h want %h", i, dut_out, {m_we, m_addr, m_data, m_state});
         end
         if (e_r0) p0v = 1'b0;
         if (e_r1) p1v = 1'b0;
      end
   endtask

`ifdef WB_FWD_EN
   task automatic test_fwd();
      apply(1'b1, 5'd7, 32'hA5A5_A5A5, 1'b0, '0, '0, 1'b0);
      tick();
      rd_addr1 = 5'd7; rd_addr2 = 5'd0;
      #1;
      checks++;
      if ({fwd1_hit, fwd2_hit, fwd_data} !== {1'b1, 1'b0, 32'hA5A5_A5A5}) begin
         errors++; $display("FAIL fwd_hit: got %h want %h", {fwd1_hit, fwd2_hit, fwd_data}, {1'b1, 1'b0, 32'hA5A5_A5A5});
      end
      rd_addr2 = 5'd7; rd_addr1 = 5'd8;
      #1;
      checks++;
      if ({fwd1_hit, fwd2_hit} !== 2'b01) begin
         errors++; $display("FAIL fwd_swap: got %b want 01", {fwd1_hit, fwd2_hit});
      end
      apply(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
      tick();
      checks++;
      if ({fwd1_hit, fwd2_hit} !== 2'b00) begin
         errors++; $display("FAIL fwd_nowe: got %b want 00", {fwd1_hit, fwd2_hit});
      end
   endtask
`endif

   initial begin
`ifdef WB_FWD_EN
      rd_addr1 = '0; rd_addr2 = '0;
`endif
      test_reset();
      test_single();
      test_contention();
      test_x0();
      test_stall();
`ifdef WB_FWD_EN
      test_fwd();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
Write-port arbiter for the 32x32 register file. Shares the single write port (A3/WD/WE) between two writeback requesters: req0 = ALU result, req1 = load data. The output is registered, so it drives the register file write port directly. Priority is fixed to loads, with a starvation counter that guarantees ALU progress. Writes to register 0 are accepted but never issued.

Parameters:
N, 5, register address width (matches register file A1/A2/A3).
M, 32, data width (matches register file WD).
STARVE_LIMIT, 4, consecutive denied cycles after which req0 takes priority (legal range 1..15).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req0_valid  in  1  ALU writeback request.
req0_addr  in  N  ALU destination register.
req0_data  in  M  ALU result.
req0_ready  out  1  ALU request accepted this cycle (combinational).
req1_valid  in  1  load writeback request.
req1_addr  in  N  load destination register.
req1_data  in  M  load data.
req1_ready  out  1  load request accepted this cycle (combinational).
stall  in  1  register file busy; blocks all acceptance.
wb_we  out  1  to register file WE (registered).
wb_addr  out  N  to register file A3 (registered).
wb_data  out  M  to register file WD (registered).
state  out  2  FSM state: 0 IDLE, 1 WRITE, 2 STALL.

Behaviour:
- Reset (async, rst_n=0): wb_we=0, wb_addr=0, wb_data=0, starve count=0, state=IDLE. Readys are 0 while in reset.
- Handshake: a request is transferred when valid && ready on a rising edge. Valid, addr and data must hold until ready. Ready never depends on the same requester's addr or data.
- Grant when stall=0:
  - If only one requester is valid, that requester gets ready=1.
  - If both are valid, req1 wins unless count==STARVE_LIMIT, in which case req0 wins.
  - At most one ready is high per cycle.
- Grant when stall=1: both readys=0.
- Latency: an accepted request appears on wb_* on the next edge; the register file writes it one edge later.
- Output register on the edge after a grant:
  - wb_addr and wb_data load the winner's addr/data.
  - wb_we = (winner addr != 0).
- No grant with stall=0: wb_we goes to 0; wb_addr and wb_data hold.
- stall=1: all wb_* hold. Re-asserting an identical write is permitted and harmless.
- Starve counter (width 4):
  - Increments, saturating at STARVE_LIMIT, when req0_valid && !req0_ready && !stall.
  - Clears when req0 is granted or req0_valid=0.
  - Holds during stall.
- FSM (next state evaluated each edge):
  - STALL if stall=1.
  - Else WRITE if any grant.
  - Else IDLE.
  - Any state can reach any state; reset returns to IDLE.
- Same destination address from both requesters in one cycle: serialized. The winner writes first and the loser on a later cycle, so the last writer is the later grant.
- Reset mid-operation: any pending, un-granted request is not remembered. Requesters re-present it after reset.
- Per-requester ordering is preserved; no buffering beyond the single output register.

Optional Feature:
Macro WB_FWD_EN, which adds read-side forwarding for writes not yet visible in the register file.
- Adds inputs rd_addr1 and rd_addr2 (N bits each).
- Adds outputs fwd1_hit, fwd2_hit (1 bit each) and fwd_data (M bits).
- fwdX_hit = wb_we && (wb_addr == rd_addrX) && (rd_addrX != 0). Combinational.
- fwd_data = wb_data.
- Without the macro, these ports and the logic do not exist; consumers read the register file only.

Test Plan:
1. Reset: rst_n=0 mid-WRITE with wb_we=1 -> wb_we=0, wb_addr=0, wb_data=0, state=IDLE immediately, without waiting for a clock edge.
2. Single request: req0 valid, addr=5, data=0xDEADBEEF, stall=0 -> req0_ready=1 same cycle; next edge wb_we=1, wb_addr=5, wb_data=0xDEADBEEF, state=WRITE; following edge wb_we=0.
3. Contention with STARVE_LIMIT=4:
   - Stimulus: both valid continuously, req1 presenting a new address every cycle.
   - Expected: req1 granted 4 cycles, then req0 granted in cycle 5; counter clears to 0.
4. x0 write: req1 addr=0, data=0x1234 -> req1_ready=1, wb_we stays 0 next cycle; register 0 reads 0.
5. Stall: stall=1 for 3 cycles with req0 valid -> readys=0, wb_* held, state=STALL, counter unchanged; stall=0 -> req0 granted next cycle.
6. WB_FWD_EN: wb_we=1, wb_addr=7, wb_data=0xA5A5A5A5, rd_addr1=7, rd_addr2=0 -> fwd1_hit=1, fwd2_hit=0, fwd_data=0xA5A5A5A5.
